// File: rtl/neuron_seq.sv
// Serial multiply-accumulate neuron: N_INPUTS (x, w) beats, bias add, ReLU, valid/ready result.
// Define NEURON_SAT_EN for saturating accumulation and the sat_flag output.
module neuron_seq #(
    parameter int DATA_W   = 8,
    parameter int N_INPUTS = 3,
    parameter int ACC_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  y,
    output logic              busy
`ifdef NEURON_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {ST_ACC, ST_BIAS, ST_ACT, ST_OUT} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DATA_W-1:0]   bias_q, bias_d;
    logic [ACC_W-1:0]           y_q, y_d;
    logic                       out_valid_q, out_valid_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    addend;
    logic signed [ACC_W-1:0]    acc_sum;

    always_comb begin
        prod   = $signed(x) * $signed(w);
        addend = ACC_W'(prod);
        if (state_q == ST_BIAS) begin
            addend = ACC_W'(bias_q);
        end
    end

`ifdef NEURON_SAT_EN
    logic             sat_q, sat_d;
    logic             clamp;
    logic [ACC_W:0]   sum_wide;

    // One guard bit: overflow exactly when the two top bits of the widened sum disagree.
    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q} + {addend[ACC_W-1], addend};
        clamp    = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        acc_sum  = sum_wide[ACC_W-1:0];
        if (clamp) begin
            acc_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    assign sat_flag = sat_q;
`else
    always_comb begin
        acc_sum = acc_q + addend;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
`ifdef NEURON_SAT_EN
        sat_d       = sat_q;
`endif
        if (clear) begin
            state_d     = ST_ACC;
            cnt_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        acc_d = acc_sum;
`ifdef NEURON_SAT_EN
                        sat_d = (cnt_q == '0) ? clamp : (sat_q | clamp);
`endif
                        if (cnt_q == '0) begin
                            bias_d = bias;
                        end
                        if (cnt_q == LAST_BEAT) begin
                            cnt_d   = '0;
                            state_d = ST_BIAS;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_BIAS: begin
                    acc_d   = acc_sum;
`ifdef NEURON_SAT_EN
                    sat_d   = sat_q | clamp;
`endif
                    state_d = ST_ACT;
                end
                ST_ACT: begin
                    y_d         = acc_q[ACC_W-1] ? '0 : acc_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        state_d     = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
`ifdef NEURON_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
`ifdef NEURON_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign busy      = (state_q != ST_ACC) || (cnt_q != '0);
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_neuron_seq.sv
// Bench for neuron_seq: two instances (ACC_W 20 and 16) share stimulus and are checked every
// cycle against a transaction-level arithmetic model; directed cases pin literal results.
module tb_neuron_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic               in_valid;
    logic               out_ready;
    logic signed [7:0]  x, w, bias;
    logic               in_ready20, in_ready16, out_valid20, out_valid16, busy20, busy16;
    logic [19:0]        y20;
    logic [15:0]        y16;
`ifdef NEURON_SAT_EN
    logic               sat20, sat16;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    neuron_seq #(.DATA_W(8), .N_INPUTS(3), .ACC_W(20)) dut20 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready20),
        .x(x), .w(w), .bias(bias), .out_valid(out_valid20), .out_ready(out_ready),
        .y(y20), .busy(busy20)
`ifdef NEURON_SAT_EN
        , .sat_flag(sat20)
`endif
    );

    neuron_seq #(.DATA_W(8), .N_INPUTS(3), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready16),
        .x(x), .w(w), .bias(bias), .out_valid(out_valid16), .out_ready(out_ready),
        .y(y16), .busy(busy16)
`ifdef NEURON_SAT_EN
        , .sat_flag(sat16)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int aw_of(input int i);
        return (i == 0) ? 20 : 16;
    endfunction

    function automatic longint fit(input longint v, input int aw, output bit clamped);
        longint hi, lo, m, r;
        hi = (longint'(1) <<< (aw - 1)) - 1;
        lo = -(longint'(1) <<< (aw - 1));
        m  = longint'(1) <<< aw;
        clamped = 1'b0;
`ifdef NEURON_SAT_EN
        r = v;
        if (v > hi) begin r = hi; clamped = 1'b1; end
        if (v < lo) begin r = lo; clamped = 1'b1; end
`else
        r = v & (m - 1);
        if (r > hi) r = r - m;
`endif
        return r;
    endfunction

    longint m_acc[2], m_pend[2], m_y[2];
    bit     m_satacc[2], m_pend_sat[2], m_sat[2];
    longint m_bias = 0;
    int     m_cnt  = 0;     // beats taken for current result
    int     m_wait = 0;     // edges left until the result is presented
    bit     m_pres = 1'b0;  // result presented, awaiting handshake

    always @(posedge clk or negedge rst) begin
        bit c;
        longint t;
        if (!rst) begin
            m_cnt = 0; m_wait = 0; m_pres = 1'b0;
            for (int i = 0; i < 2; i++) begin m_y[i] = 0; m_acc[i] = 0; end
        end else if (clear) begin
            m_cnt = 0; m_wait = 0; m_pres = 1'b0;
        end else if (m_pres) begin
            if (out_ready) m_pres = 1'b0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_pres = 1'b1;
                for (int i = 0; i < 2; i++) begin m_y[i] = m_pend[i]; m_sat[i] = m_pend_sat[i]; end
            end
        end else if (in_valid) begin
            if (m_cnt == 0) begin
                m_bias = longint'(bias);
                for (int i = 0; i < 2; i++) begin m_acc[i] = 0; m_satacc[i] = 1'b0; end
            end
            for (int i = 0; i < 2; i++) begin
                m_acc[i] = fit(m_acc[i] + longint'(x) * longint'(w), aw_of(i), c);
                m_satacc[i] |= c;
            end
            m_cnt++;
            if (m_cnt == 3) begin
                m_cnt  = 0;
                m_wait = 2;
                for (int i = 0; i < 2; i++) begin
                    t = fit(m_acc[i] + m_bias, aw_of(i), c);
                    m_satacc[i] |= c;
                    m_pend[i]     = (t < 0) ? 0 : t;
                    m_pend_sat[i] = m_satacc[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        bit exp_ready;
        exp_ready = !(m_wait > 0 || m_pres);
        chk("in_ready20", in_ready20, exp_ready);
        chk("in_ready16", in_ready16, exp_ready);
        chk("out_valid20", out_valid20, m_pres);
        chk("out_valid16", out_valid16, m_pres);
        chk("busy20", busy20, (m_cnt != 0) || !exp_ready);
        chk("busy16", busy16, (m_cnt != 0) || !exp_ready);
        chk("y20", y20, m_y[0]);
        chk("y16", y16, m_y[1]);
`ifdef NEURON_SAT_EN
        if (m_pres) begin
            chk("sat20", sat20, m_sat[0]);
            chk("sat16", sat16, m_sat[1]);
        end
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int xv, input int wv, input int bv);
        bit took;
        took = 1'b0;
        in_valid = 1'b1;
        x = 8'(xv); w = 8'(wv); bias = 8'(bv);
        for (int k = 0; k < 20 && !took; k++) begin
            took = in_ready20;
            tick();
        end
        in_valid = 1'b0;
        if (!took) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_out();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (out_valid20) seen = 1'b1;
            else tick();
        end
        chk("wait_out", seen, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic basic();
        send(2, 4, 1);
        send(3, 5, int'($urandom_range(0, 255)) - 128);
        send(-1, 6, int'($urandom_range(0, 255)) - 128);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; w = '0; bias = '0;
        #3;
        chk("rst_in_ready", in_ready20, 1);
        chk("rst_out_valid", out_valid20, 0);
        chk("rst_y", y20, 0);
        chk("rst_busy", busy20, 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // basic result and latency
        basic();
        chk("lat_bias_in_ready", in_ready20, 0);
        chk("lat_bias_out_valid", out_valid20, 0);
        tick();
        chk("lat_act_out_valid", out_valid20, 0);
        tick();
        chk("lat_out_valid", out_valid20, 1);
        chk("basic_y", y20, 18);

        // backpressure with ignored beats
        in_valid = 1'b1; x = 9; w = 9;
        repeat (5) tick();
        in_valid = 1'b0;
        chk("bp_out_valid", out_valid20, 1);
        chk("bp_y", y20, 18);
        handshake();
        chk("post_hs_in_ready", in_ready20, 1);
        chk("post_hs_y_held", y20, 18);

        // ReLU clamps negative sum
        send(-10, 10, -3); send(5, 2, 0); send(0, 7, 0);
        wait_out();
        chk("relu_y", y20, 0);
        handshake();

        // clear mid-run
        send(2, 4, 1); send(3, 5, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_busy", busy20, 0);
        basic();
        wait_out();
        chk("clear_then_basic_y", y20, 18);
        handshake();

        // reset mid-run
        send(2, 4, 1); send(3, 5, 0);
        rst = 1'b0;
        #1;
        chk("midrst_y", y20, 0);
        chk("midrst_busy", busy20, 0);
        tick();
        rst = 1'b1;
        basic();
        wait_out();
        chk("rst_then_basic_y", y20, 18);
        handshake();

        // extremes and 16-bit overflow
        send(-128, -128, 127); send(-128, -128, 0); send(-128, -128, 0);
        wait_out();
        chk("extreme_y20", y20, 49279);
`ifdef NEURON_SAT_EN
        chk("extreme_y16_sat", y16, 32767);
        chk("extreme_sat16", sat16, 1);
`else
        chk("extreme_y16_wrap", y16, 0);
`endif
        handshake();
        basic();
        wait_out();
        chk("basic_y16", y16, 18);
`ifdef NEURON_SAT_EN
        chk("basic_sat16_clear", sat16, 0);
`endif
        handshake();

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            x         = 8'($urandom);
            w         = 8'($urandom);
            bias      = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin x = -128; w = -128; end
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            tick();
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/neuron_seq.md
Name: neuron_seq

Overview:
- Parametrised, handshaked successor to the single-input neuron datapath.
- Accepts N_INPUTS (x, w) pairs serially over a valid/ready stream and accumulates their signed products in an ACC_W accumulator.
- Adds a per-neuron bias, applies ReLU, and presents one result on a valid/ready output port.
- Building block for fully-connected layers: one instance per output neuron, fed by the layer sequencer.

Parameters:
DATA_W, 8, signed width of x, w and bias
N_INPUTS, 3, number of (x, w) beats per result; >= 1
ACC_W, 20, signed accumulator and output width; must be >= 2*DATA_W
CNT_W, $clog2(N_INPUTS+1), beat counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
clear  in  1  synchronous abort; discards partial sum and returns to ACC
in_valid  in  1  x/w/bias beat valid
in_ready  out  1  block can accept a beat
x  in  DATA_W  signed input activation
w  in  DATA_W  signed weight
bias  in  DATA_W  signed bias; sampled only on the first beat of a result
out_valid  out  1  y holds a completed result
out_ready  in  1  downstream accepts y
y  out  ACC_W  signed activated output, always >= 0
busy  out  1  high when state != ACC or beat count != 0

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
- Reset values: state = ACC, beat count = 0, acc = 0, bias_reg = 0, y = 0, out_valid = 0, busy = 0.
- in_ready = (state == ACC), combinational from state. It is 1 immediately after reset.
- FSM states: ACC, BIAS, ACT, OUT.
- ACC state:
  - A beat is accepted on an edge where in_valid && in_ready.
  - acc <= acc + sext(x*w), with the product computed as a full 2*DATA_W signed value.
  - Beat count increments; on beat 0, bias_reg <= bias.
  - When the accepted beat is number N_INPUTS-1: count <= 0, go to BIAS.
- BIAS state: acc <= acc + sext(bias_reg), then go to ACT. Lasts exactly 1 cycle.
- ACT state: y <= (acc < 0) ? 0 : acc; out_valid <= 1; go to OUT. Lasts exactly 1 cycle.
- OUT state:
  - out_valid held high; y stable; in_valid ignored.
  - On an edge with out_ready: out_valid <= 0, acc <= 0, go to ACC.
  - y keeps its last value after the handshake until the next ACT.
- Latency: out_valid rises on the 2nd rising edge after the edge that accepted the last beat. Minimum throughput is one result per N_INPUTS+3 cycles (out_ready held high).
- Arithmetic: all two's complement. Without the optional feature, the accumulator wraps modulo 2^ACC_W.
- clear:
  - In any state, on the next edge: state = ACC, count = 0, acc = 0, out_valid = 0. y is unchanged.
  - clear has priority over a simultaneous beat (that beat is dropped) and over a simultaneous output handshake.
- Reset mid-operation: everything returns to reset values at once, and any partial sum is lost.
- N_INPUTS = 1: the first beat goes directly to BIAS.
- out_ready high while out_valid is low has no effect.

Optional Feature:
- Macro: NEURON_SAT_EN.
- Defined: every accumulator update (product add and bias add) saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping. An extra output port sat_flag (1 bit) is added. It is cleared at result start (beat 0) and sticky-set when any clamp occurs during that result. It is valid with out_valid.
- Undefined: wrapping arithmetic and no sat_flag port; saturation logic is absent from the netlist.

Test Plan:
- Basic (defaults): x = (2, 3, -1), w = (4, 5, 6), bias = 1 -> out_valid 2 cycles after 3rd beat, y = 18. in_ready low from the BIAS state until the handshake.
- ReLU: x = (-10, 5, 0), w = (10, 2, 7), bias = -3 -> sum -93, y = 0, out_valid = 1.
- Backpressure: after Basic, hold out_ready = 0 for 5 cycles and drive in_valid = 1 with x = w = 9. Required: out_valid and y = 18 stable, no beat accepted, then one handshake returns to ACC and the next result is unaffected.
- Reset/clear mid-run:
  - Accept 2 beats, then pulse clear -> busy = 0 next cycle; Basic vectors then give y = 18.
  - Repeat with rst low for 1 cycle instead of clear -> same outcome, and y = 0 from the reset.
- Extremes (ACC_W = 20): x = w = -128 for all 3 beats, bias = 127 -> y = 49279.
- Overflow (ACC_W = 16, same extremes as above):
  - Without NEURON_SAT_EN: y = 0 (wrapped sum -16257).
  - With NEURON_SAT_EN: y = 32767 and sat_flag = 1. The next Basic run gives sat_flag = 0.
